log_mult_sequencer: RTL and testbench
=====================================

LOG_MULT_SEQUENCER -- requirements
Module: log_mult_sequencer

Interface
REQ-001 Parameters: none; operand width fixed at 8 bits, product width fixed at 16 bits.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high (ports clk and rst).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operand pair a/b presented.
REQ-006 in_ready  output  1  block can accept a pair; high only in IDLE.
REQ-007 a  input  8  unsigned multiplicand, sampled on accept.
REQ-008 b  input  8  unsigned multiplier, sampled on accept.
REQ-009 out_valid  output  1  product holds a result.
REQ-010 out_ready  input  1  consumer takes the product.
REQ-011 product  output  16  approximate (Mitchell) product a*b, unsigned.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The block SHALL contain exactly one log_calculator instance (8-bit in; 3-bit characteristic k; 7-bit fraction f). It is time-shared between a and b through an input mux driven by the FSM.
REQ-014 log_calculator contract: k = index of the leading one; f = bits below the leading one, left-aligned into 7 bits, zero-filled; in=0 gives k=0, f=0.
REQ-015 FSM states: IDLE, LOG_A, LOG_B, CALC, DONE. Encoding is free.
REQ-016 IDLE: accept when in_valid && in_ready; at that edge latch a, b and zero_flag=(a==0)||(b==0), then go to LOG_A.
REQ-017 LOG_A: mux selects latched a; register kA, fA; go to LOG_B.
REQ-018 LOG_B: mux selects latched b; register kB, fB; go to CALC.
REQ-019 CALC: compute S=fA+fB (8 bits).
 - S>=128: K=kA+kB+1, F=S-128.
 - Otherwise: K=kA+kB, F=S.
 - Register product = ((128+F) << K) >> 7, truncated toward zero.
 - zero_flag set: register product = 0.
 - Go to DONE.
REQ-020 Intermediate (128+F)<<K SHALL be at least 23 bits wide. The result always fits 16 bits; max input (255,255) gives 65024.
REQ-021 DONE: out_valid=1; product stable. On out_valid && out_ready go to IDLE, and out_valid drops the next cycle.
REQ-022 Latency: accept at edge E gives out_valid high after edge E+3. With out_ready held high, a new pair can be accepted at edge E+5.
REQ-023 in_valid while not in IDLE SHALL be ignored; a and b changes after accept SHALL NOT affect the result.
REQ-024 product SHALL retain its last value after handshake until the next CALC overwrites it.
REQ-025 out_ready while not in DONE SHALL be ignored.

Reset
REQ-026 rst=1 at an edge SHALL force, from any state:
 - state=IDLE.
 - out_valid=0, busy=0, in_ready=1.
 - product=0; internal kA/fA/kB/fB/zero_flag=0.
REQ-027 Reset mid-operation (LOG_A..DONE) SHALL discard the in-flight result; no out_valid pulse follows.
REQ-028 rst and in_valid high together: rst wins and no pair is accepted.

Verification
REQ-029 a=3, b=5, out_ready=1 -> out_valid 3 cycles after accept; product=14 (kA=1, fA=64, kB=2, fB=32).
REQ-030 a=6, b=6 -> fraction carry path (S=128, K=5, F=0); product=32.
REQ-031 a=255, b=255 -> product=65024; a=1, b=1 -> product=1; a=16, b=8 -> product=128 (exact).
REQ-032 a=0, b=200 and a=200, b=0 -> product=0.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and product stable, in_ready=0, new in_valid ignored; raise out_ready -> one transfer, then IDLE.
REQ-034 Assert rst during LOG_B, then release -> IDLE, out_valid never asserted, product=0; next pair a=3, b=5 -> product=14.

Source files
------------

// File: rtl/log_mult_sequencer.sv
// Mitchell approximate 8x8 multiplier. A single leading-one/fraction
// extractor is time-shared between the two operands, then the log-domain
// sum is turned back into a linear product.

module log_calculator (
    input  logic [7:0] in_val,
    output logic [2:0] k,
    output logic [6:0] f
);
    logic [7:0] shifted;

    // Find the leading one and left-align the bits below it into the fraction
    always_comb begin
        k = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (in_val[i]) begin
                k = 3'(i);
            end
        end
        shifted = in_val << (3'd7 - k);
        f       = shifted[6:0];
    end
endmodule

module log_mult_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOG_A = 3'd1,
        LOG_B = 3'd2,
        CALC  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic        zero_q, zero_d;
    logic [2:0]  ka_q, ka_d;
    logic [6:0]  fa_q, fa_d;
    logic [2:0]  kb_q, kb_d;
    logic [6:0]  fb_q, fb_d;
    logic [15:0] product_q, product_d;

    logic [7:0]  log_in;
    logic [2:0]  log_k;
    logic [6:0]  log_f;

    logic [7:0]  frac_sum;
    logic [3:0]  k_total;
    logic [6:0]  f_total;
    logic [22:0] scaled;
    logic [15:0] product_calc;

    logic        accept;

    assign accept = in_valid && (state_q == IDLE);

    // Operand mux feeding the shared log unit: b only while in LOG_B
    always_comb begin
        log_in = (state_q == LOG_B) ? b_q : a_q;
    end

    log_calculator u_log (
        .in_val (log_in),
        .k      (log_k),
        .f      (log_f)
    );

    // Antilog: add fractions, fold a carry into the characteristic, shift back
    always_comb begin
        frac_sum = {1'b0, fa_q} + {1'b0, fb_q};
        if (frac_sum[7]) begin
            k_total = {1'b0, ka_q} + {1'b0, kb_q} + 4'd1;
        end else begin
            k_total = {1'b0, ka_q} + {1'b0, kb_q};
        end
        f_total      = frac_sum[6:0];
        scaled       = 23'({1'b1, f_total}) << k_total;
        product_calc = scaled[22:7];
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            zero_q    <= 1'b0;
            ka_q      <= 3'd0;
            fa_q      <= 7'd0;
            kb_q      <= 3'd0;
            fb_q      <= 7'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            zero_q    <= zero_d;
            ka_q      <= ka_d;
            fa_q      <= fa_d;
            kb_q      <= kb_d;
            fb_q      <= fb_d;
            product_q <= product_d;
        end
    end

    // Next-state logic and datapath register updates
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        zero_d    = zero_q;
        ka_d      = ka_q;
        fa_d      = fa_q;
        kb_d      = kb_q;
        fb_d      = fb_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    zero_d  = (a == 8'd0) || (b == 8'd0);
                    state_d = LOG_A;
                end
            end
            LOG_A: begin
                ka_d    = log_k;
                fa_d    = log_f;
                state_d = LOG_B;
            end
            LOG_B: begin
                kb_d    = log_k;
                fb_d    = log_f;
                state_d = CALC;
            end
            CALC: begin
                product_d = zero_q ? 16'd0 : product_calc;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        product   = product_q;
    end
endmodule

// File: tb/tb_log_mult_sequencer.sv
// Directed self-checking bench for log_mult_sequencer.

module tb_log_mult_sequencer;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int total;
    int bad;

    log_mult_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a pair until accepted; returns the number of rising edges
    // spent, the last being the accept edge. Afterwards scramble a/b.
    task automatic send(input logic [7:0] ai, input logic [7:0] bi, output int edges);
        logic was_ready;
        edges = 0;
        @(negedge clk);
        a = ai;
        b = bi;
        in_valid = 1'b1;
        forever begin
            was_ready = in_ready;
            @(posedge clk);
            edges++;
            if (was_ready || edges > 50) break;
            @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
    endtask

    // Count edges until out_valid is seen, bounded
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        a = 8'd3;
        b = 8'd5;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_state: in_ready=%b busy=%b out_valid=%b product=%0d, want 1 0 0 0",
                     in_ready, busy, out_valid, product);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_wins_over_valid: busy=%b in_ready=%b, want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [7:0]  va [7];
        logic [7:0]  vb [7];
        logic [15:0] vp [7];
        int edges;
        int cycles;
        va = '{8'd3, 8'd6, 8'd255, 8'd1, 8'd16, 8'd0, 8'd200};
        vb = '{8'd5, 8'd6, 8'd255, 8'd1, 8'd8, 8'd200, 8'd0};
        vp = '{16'd14, 16'd32, 16'd65024, 16'd1, 16'd128, 16'd0, 16'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send(va[i], vb[i], edges);
            wait_done(cycles);
            total++;
            if (cycles !== 3) begin
                bad++;
                $display("[TB] FAIL latency_%0d: got %0d cycles, want 3", i, cycles);
            end
            total++;
            if (product !== vp[i]) begin
                bad++;
                $display("[TB] FAIL product_%0dx%0d: got %0d, want %0d", va[i], vb[i], product, vp[i]);
            end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== vp[i]) begin
                bad++;
                $display("[TB] FAIL after_handshake_%0d: out_valid=%b in_ready=%b product=%0d, want 0 1 %0d",
                         i, out_valid, in_ready, product, vp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        int cycles;
        out_ready = 1'b1;
        send(8'd16, 8'd8, edges);
        wait_done(cycles);
        send(8'd3, 8'd5, edges);
        total++;
        if (edges !== 2) begin
            bad++;
            $display("[TB] FAIL back_to_back_accept: accepted after %0d edges, want 2", edges);
        end
        wait_done(cycles);
        total++;
        if (cycles !== 3 || product !== 16'd14) begin
            bad++;
            $display("[TB] FAIL back_to_back_result: cycles=%0d product=%0d, want 3 14", cycles, product);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int edges;
        int cycles;
        int errs;
        out_ready = 1'b0;
        send(8'd6, 8'd6, edges);
        wait_done(cycles);
        total++;
        if (out_valid !== 1'b1 || product !== 16'd32) begin
            bad++;
            $display("[TB] FAIL bp_enter_done: out_valid=%b product=%0d, want 1 32", out_valid, product);
        end
        errs = 0;
        in_valid = 1'b1;
        a = 8'd255;
        b = 8'd255;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || product !== 16'd32 || in_ready !== 1'b0 || busy !== 1'b1) errs++;
        end
        in_valid = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("[TB] FAIL bp_hold: %0d cycles unstable, want 0", errs);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 16'd32) begin
            bad++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b product=%0d, want 0 1 32",
                     out_valid, in_ready, product);
        end
    endtask

    task automatic test_reset_mid_op();
        int edges;
        int cycles;
        int seen;
        out_ready = 1'b1;
        send(8'd200, 8'd100, edges);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || product !== 16'd0) begin
            bad++;
            $display("[TB] FAIL mid_reset_state: in_ready=%b busy=%b product=%0d, want 1 0 0",
                     in_ready, busy, product);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL mid_reset_no_valid: out_valid seen %0d cycles, want 0", seen);
        end
        send(8'd3, 8'd5, edges);
        wait_done(cycles);
        total++;
        if (cycles !== 3 || product !== 16'd14) begin
            bad++;
            $display("[TB] FAIL mid_reset_recover: cycles=%0d product=%0d, want 3 14", cycles, product);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = 8'd0;
        b = 8'd0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
